uart_tx_arbiter: RTL and testbench

Shares a single UART transmitter between NUM_REQ byte-stream requesters, e.g. the RX→FIFO echo path and a status/message generator. Drives the transmitter's data-valid/byte inputs, tracks its active/done handshake, and grants round-robin. A requester keeps the grant for a whole packet, up to its last byte. A start watchdog recovers if the transmitter never goes active.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/rr_picker.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART blocks: arbiter state encodings,
//   the default start-watchdog length, baud constants and a small index
//   helper used by round-robin logic.
//   No ports (package).
package uart_pkg;

  // Arbiter state encodings, kept as plain 2-bit constants so other blocks
  // (status readback, debug taps) can compare against them directly.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_SEND  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ISSUE = ST_ISSUE,
    START = ST_START,
    SEND  = ST_SEND
  } arb_state_t;

  localparam int DEFAULT_START_TIMEOUT = 16;

  // Baud constants shared with the UART rx/tx blocks.
  localparam int CLK_FREQ_HZ  = 25_000_000;
  localparam int BAUD_RATE    = 115_200;
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;

  // Index following idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rr_picker
//   Combinational round-robin select: returns the first set bit of valid
//   at or after ptr, wrapping modulo N.
//   Ports:
//     valid      in  N   request vector
//     ptr        in  IW  highest-priority index this cycle (must be < N)
//     winner     out N   one-hot winner, 0 when no request
//     winner_idx out IW  index of the winner, 0 when no request
//     any        out 1   at least one request present
module rr_picker #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [IW-1:0] winner_idx,
  output logic          any
);

  // NOTE: every output gets a default before the search loop; a path that
  // leaves one unassigned would make synthesis infer a latch.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && valid[(int'(ptr) + i) % N]) begin
        any                         = 1'b1;
        winner[(int'(ptr) + i) % N] = 1'b1;
        winner_idx                  = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ byte-stream requesters.
//   Round-robin between packets; a requester keeps the grant until the
//   byte flagged last completes. A start watchdog abandons a byte when the
//   transmitter never reports active.
//   Ports:
//     i_clk, i_reset     clock, asynchronous active-high reset
//     i_req_valid[k]     requester k has a byte
//     i_req_data         byte of requester k at [8k+7:8k]
//     i_req_last[k]      byte ends the packet (releases the lock)
//     o_req_ready[k]     byte of requester k taken this cycle (comb, IDLE only)
//     o_tx_byte          byte to transmitter, stable from ISSUE to next capture
//     o_tx_dv            one-cycle start pulse to transmitter
//     i_tx_active        transmitter busy
//     i_tx_done          transmitter one-cycle completion pulse
//     o_grant            one-hot current owner, 0 when unlocked
//     o_busy             FSM not in IDLE
//     o_timeout          one-cycle pulse when the start watchdog expires
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  input  logic [8*NUM_REQ-1:0] i_req_data,
  input  logic [NUM_REQ-1:0]   i_req_last,
  output logic [NUM_REQ-1:0]   o_req_ready,
  output logic [7:0]           o_tx_byte,
  output logic                 o_tx_dv,
  input  logic                 i_tx_active,
  input  logic                 i_tx_done,
  output logic [NUM_REQ-1:0]   o_grant,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(START_TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(START_TIMEOUT - 1);

  arb_state_t           state_q, state_d;
  logic [IW-1:0]        owner_q, ptr_q;
  logic                 locked_q, last_q;
  logic [7:0]           byte_q;
  logic [WD_W-1:0]      wd_q;
  logic                 tx_dv_q, busy_q, timeout_q;
  logic [NUM_REQ-1:0]   grant_q;

  logic [NUM_REQ-1:0]   rr_winner;
  logic [IW-1:0]        rr_idx;
  logic                 rr_any;

  logic                 sel_valid;
  logic [IW-1:0]        sel_idx;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic                 byte_done;
  logic                 wd_expire;

  rr_picker #(.N(NUM_REQ), .IW(IW)) u_rr_picker (
    .valid      (i_req_valid),
    .ptr        (ptr_q),
    .winner     (rr_winner),
    .winner_idx (rr_idx),
    .any        (rr_any)
  );

  // Next state and per-cycle decisions.
  always_comb begin
    state_d    = state_q;
    sel_valid  = 1'b0;
    sel_idx    = owner_q;
    sel_onehot = '0;
    byte_done  = 1'b0;
    wd_expire  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (locked_q) begin
          // Mid-packet: only the owner may continue.
          if (i_req_valid[owner_q]) begin
            sel_valid           = 1'b1;
            sel_onehot[owner_q] = 1'b1;
          end
        end else if (rr_any) begin
          sel_valid  = 1'b1;
          sel_idx    = rr_idx;
          sel_onehot = rr_winner;
        end
        if (sel_valid) state_d = ISSUE;
      end
      ISSUE: state_d = START;
      START: begin
        // Done wins over active: a zero-latency transmitter may complete
        // without ever showing active.
        if (i_tx_done) begin
          state_d   = IDLE;
          byte_done = 1'b1;
        end else if (i_tx_active) begin
          state_d = SEND;
        end else if (wd_q == WD_LAST) begin
          state_d   = IDLE;
          wd_expire = 1'b1;
        end
      end
      SEND: begin
        if (i_tx_done) begin
          state_d   = IDLE;
          byte_done = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is written with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      locked_q  <= 1'b0;
      last_q    <= 1'b0;
      byte_q    <= '0;
      wd_q      <= '0;
      tx_dv_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
    end else begin
      state_q   <= state_d;
      tx_dv_q   <= (state_d == ISSUE);
      busy_q    <= (state_d != IDLE);
      timeout_q <= wd_expire;

      if (state_q == ISSUE)      wd_q <= '0;
      else if (state_q == START) wd_q <= wd_q + 1'b1;

      if (sel_valid) begin
        byte_q   <= i_req_data[8*int'(sel_idx) +: 8];
        last_q   <= i_req_last[sel_idx];
        owner_q  <= sel_idx;
        locked_q <= 1'b1;
        grant_q  <= sel_onehot;
      end

      // Packet end or abandoned start: release and rotate past the owner.
      if (wd_expire || (byte_done && last_q)) begin
        locked_q <= 1'b0;
        grant_q  <= '0;
        ptr_q    <= IW'(wrap_inc(int'(owner_q), NUM_REQ));
      end
    end
  end

  // Ready is gated by reset so no requester sees its byte taken while the
  // block is held in reset.
  assign o_req_ready = sel_onehot & {NUM_REQ{~i_reset}};
  assign o_tx_byte   = byte_q;
  assign o_tx_dv     = tx_dv_q;
  assign o_grant     = grant_q;
  assign o_busy      = busy_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR = 2;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [NR-1:0]   i_req_valid;
  logic [8*NR-1:0] i_req_data;
  logic [NR-1:0]   i_req_last;
  logic [NR-1:0]   o_req_ready;
  logic [7:0]      o_tx_byte;
  logic            o_tx_dv;
  logic            i_tx_active;
  logic            i_tx_done;
  logic [NR-1:0]   o_grant;
  logic            o_busy;
  logic            o_timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .START_TIMEOUT(16)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_req_valid (i_req_valid),
    .i_req_data  (i_req_data),
    .i_req_last  (i_req_last),
    .o_req_ready (o_req_ready),
    .o_tx_byte   (o_tx_byte),
    .o_tx_dv     (o_tx_dv),
    .i_tx_active (i_tx_active),
    .i_tx_done   (i_tx_done),
    .o_grant     (o_grant),
    .o_busy      (o_busy),
    .o_timeout   (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, want, $time);
  endtask

  typedef struct packed { logic [7:0] d; logic last; } item_t;
  typedef struct packed { logic [7:0] d; logic [NR-1:0] gnt; } exp_t;

  item_t q0[$];
  item_t q1[$];
  exp_t  exp_q[$];

  task automatic exp_push(input logic [7:0] d, input logic [NR-1:0] gnt);
    exp_t e;
    e.d = d; e.gnt = gnt;
    exp_q.push_back(e);
  endtask

  task automatic req_push(input int k, input logic [7:0] d, input logic last);
    item_t it;
    it.d = d; it.last = last;
    if (k == 0) q0.push_back(it);
    else        q1.push_back(it);
  endtask

  // ---------------- requester driver ----------------
  initial begin
    logic [NR-1:0] rdy;
    i_req_valid = '0;
    i_req_data  = '0;
    i_req_last  = '0;
    forever begin
      @(negedge i_clk);
      rdy = o_req_ready;
      @(posedge i_clk);
      #1;
      if (rdy[0] && q0.size() != 0) q0.delete(0);
      if (rdy[1] && q1.size() != 0) q1.delete(0);
      i_req_valid[0]   = (q0.size() != 0);
      i_req_data[7:0]  = (q0.size() != 0) ? q0[0].d : 8'h00;
      i_req_last[0]    = (q0.size() != 0) ? q0[0].last : 1'b0;
      i_req_valid[1]   = (q1.size() != 0);
      i_req_data[15:8] = (q1.size() != 0) ? q1[0].d : 8'h00;
      i_req_last[1]    = (q1.size() != 0) ? q1[0].last : 1'b0;
    end
  end

  // ---------------- transmitter model ----------------
  typedef enum int { TX_NORMAL, TX_ZERO, TX_DEAD } tx_mode_t;
  tx_mode_t tx_mode = TX_NORMAL;

  initial begin
    i_tx_active = 1'b0;
    i_tx_done   = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (o_tx_dv) begin
        case (tx_mode)
          TX_NORMAL: begin
            repeat (3) begin @(posedge i_clk); #1; end
            i_tx_active = 1'b1;
            repeat (10) begin @(posedge i_clk); #1; end
            i_tx_active = 1'b0;
            i_tx_done   = 1'b1;
            @(posedge i_clk); #1;
            i_tx_done   = 1'b0;
          end
          TX_ZERO: begin
            @(posedge i_clk); #1;
            i_tx_done = 1'b1;
            @(posedge i_clk); #1;
            i_tx_done = 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [NR-1:0] prev_rdy = '0;
  logic          prev_dv  = 1'b0;
  int            last_dv_cyc  = 0;
  int            phase_dv_cnt = 0;
  bit            spacing_on   = 1'b0;
  int            ready0_cnt   = 0;
  int            timeout_cnt  = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (o_tx_dv) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_dv", 32'(o_tx_byte), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check(o_tx_byte == e.d, "tx_byte", 32'(o_tx_byte), 32'(e.d));
          check(o_grant == e.gnt, "grant_at_dv", 32'(o_grant), 32'(e.gnt));
        end
        check(prev_rdy != 0 && !prev_dv, "dv_one_cycle_after_ready",
              32'({prev_dv, prev_rdy}), 32'h1);
        check(o_busy, "busy_with_dv", 32'(o_busy), 32'h1);
        if (spacing_on && phase_dv_cnt > 0)
          check(cyc - last_dv_cyc == 3, "zero_lat_spacing",
                32'(cyc - last_dv_cyc), 32'd3);
        phase_dv_cnt++;
        last_dv_cyc = cyc;
      end
      if (o_req_ready != 0) begin
        check($onehot(o_req_ready) && !o_busy, "ready_onehot_in_idle",
              32'({o_busy, o_req_ready}), 32'h1);
        if (o_req_ready[0]) ready0_cnt++;
      end
      if (o_timeout) begin
        timeout_cnt++;
        // dv cycle + 16 START cycles (counter 0..15) + registered pulse.
        check(cyc - last_dv_cyc == 17, "timeout_latency",
              32'(cyc - last_dv_cyc), 32'd17);
        check(o_grant == '0, "grant_clear_on_timeout", 32'(o_grant), 32'h0);
      end
      prev_rdy = o_req_ready;
      prev_dv  = o_tx_dv;
    end
  end

  // Wait for all queued bytes to be issued and the arbiter to go idle.
  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0 || o_busy)
           && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= budget) check(1'b0, name, 32'(exp_q.size()), 32'h0);
    repeat (2) @(negedge i_clk);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    int n;

    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    check({o_tx_dv, o_busy, o_timeout} == 3'b000, "reset_flags",
          32'({o_tx_dv, o_busy, o_timeout}), 32'h0);
    check(o_grant == '0, "reset_grant", 32'(o_grant), 32'h0);
    check(o_tx_byte == 8'h00, "reset_byte", 32'(o_tx_byte), 32'h0);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);

    // Single byte from req0.
    req_push(0, 8'h41, 1'b1);
    exp_push(8'h41, 2'b01);
    wait_idle(200, "single_timeout");
    check(o_grant == '0, "single_grant_cleared", 32'(o_grant), 32'h0);
    check(o_busy == 1'b0, "single_busy_fell", 32'(o_busy), 32'h0);

    // Locked packet from req1 while req0 waits (pointer now at 1).
    ready0_cnt = 0;
    req_push(1, 8'hA0, 1'b0);
    req_push(1, 8'hA1, 1'b0);
    req_push(1, 8'hA2, 1'b1);
    req_push(0, 8'h50, 1'b1);
    exp_push(8'hA0, 2'b10);
    exp_push(8'hA1, 2'b10);
    exp_push(8'hA2, 2'b10);
    exp_push(8'h50, 2'b01);
    wait_idle(400, "lock_timeout");
    check(ready0_cnt == 1, "lock_ready0_once", 32'(ready0_cnt), 32'd1);

    // Serve req1 once so the pointer returns to req0.
    req_push(1, 8'h5F, 1'b1);
    exp_push(8'h5F, 2'b10);
    wait_idle(200, "rewind_timeout");

    // Round-robin interleave, single-byte packets.
    for (int i = 0; i < 4; i++) begin
      req_push(0, 8'h10 + 8'(i), 1'b1);
      req_push(1, 8'h20 + 8'(i), 1'b1);
      exp_push(8'h10 + 8'(i), 2'b01);
      exp_push(8'h20 + 8'(i), 2'b10);
    end
    wait_idle(800, "interleave_timeout");

    // Zero-latency transmitter: completes from START, every 3 cycles.
    tx_mode      = TX_ZERO;
    phase_dv_cnt = 0;
    spacing_on   = 1'b1;
    t0           = timeout_cnt;
    for (int i = 0; i < 4; i++) begin
      req_push(0, 8'h30 + 8'(i), 1'b1);
      exp_push(8'h30 + 8'(i), 2'b01);
    end
    wait_idle(200, "zero_lat_timeout");
    spacing_on = 1'b0;
    check(timeout_cnt == t0, "zero_lat_no_timeout", 32'(timeout_cnt - t0), 32'h0);

    // Dead transmitter: every byte is abandoned; pointer at 1 here.
    tx_mode = TX_DEAD;
    t0      = timeout_cnt;
    req_push(0, 8'h70, 1'b0);
    req_push(0, 8'h72, 1'b1);
    req_push(1, 8'h71, 1'b1);
    exp_push(8'h71, 2'b10);
    exp_push(8'h70, 2'b01);
    exp_push(8'h72, 2'b01);
    wait_idle(300, "dead_timeout");
    check(timeout_cnt - t0 == 3, "timeout_count", 32'(timeout_cnt - t0), 32'd3);

    // Reset during SEND.
    tx_mode = TX_NORMAL;
    req_push(0, 8'h55, 1'b1);
    exp_push(8'h55, 2'b01);
    n = 0;
    while (!i_tx_active && n < 100) begin @(negedge i_clk); n++; end
    if (n >= 100) check(1'b0, "wait_active", 32'(i_tx_active), 32'h1);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    check({o_tx_dv, o_busy, o_timeout} == 3'b000, "midreset_flags",
          32'({o_tx_dv, o_busy, o_timeout}), 32'h0);
    check(o_grant == '0, "midreset_grant", 32'(o_grant), 32'h0);
    check(o_req_ready == '0, "midreset_ready", 32'(o_req_ready), 32'h0);
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    n = 0;
    while (!i_tx_done && n < 100) begin @(negedge i_clk); n++; end
    if (n >= 100) check(1'b0, "wait_stale_done", 32'(i_tx_done), 32'h1);
    repeat (2) @(negedge i_clk);
    check(o_busy == 1'b0, "stale_done_ignored", 32'(o_busy), 32'h0);
    // Pointer was reset to 0, so req0 wins the tie.
    req_push(1, 8'h66, 1'b1);
    req_push(0, 8'h67, 1'b1);
    exp_push(8'h67, 2'b01);
    exp_push(8'h66, 2'b10);
    wait_idle(300, "post_reset_timeout");
    check(o_grant == '0, "post_reset_grant_cleared", 32'(o_grant), 32'h0);

    repeat (3) @(negedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: got sim time %0t want completion", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule
